tqvp_snes_controller_emulator: RTL and testbench
================================================

# tqvp_snes_controller_emulator

TinyQV byte peripheral that acts as the controller end of the NES/SNES serial pad protocol. The console or host drives latch and clock, and this block shifts out CPU-programmed button states on the data line. It is the responder counterpart to the team's controller-reader peripheral and uses the same button bit mapping, so one TinyQV board can emulate a pad for another.

## Interface
- No parameters.
- `clk` in 1: TinyQV system clock, 64 MHz nominal.
- `rst_n` in 1: asynchronous, active-low reset.
- `ui_in` in 8: input PMOD, already 2-flop synchronized by TinyQV.
  - [5] = console latch.
  - [6] = console clock.
  - Other bits unused.
- `uo_out` out 8: output PMOD.
  - [1] = serial data to console.
  - All other bits are constant 0.
- `address` in 4: register select.
- `data_write` in 1: write strobe, valid for one cycle.
- `data_in` in 8: write data.
- `data_out` out 8: read data, combinational from `address`.

## Operation
Registers. Writes happen when `data_write`=1. Unlisted addresses read 0 and ignore writes.
- 0x0 CTRL (rw): bit0 MODE (0 = NES, 1 = SNES); bit1 EN. Bits 7:2 read 0.
- 0x1 BTN (rw): 1 = pressed.
  - Bit 7 A, bit 6 B, bit 5 Select, bit 4 Start, bit 3 Up, bit 2 Down, bit 1 Left, bit 0 Right.
- 0x2 XBTN (rw): bit 3 X, bit 2 Y, bit 1 L, bit 0 R. Bits 7:4 read 0.
- 0x3 POLLS (r): 8-bit count of latch falling edges, wraps 255 -> 0. Any write clears it to 0.

Frame contents:
- Wire level is inverted: pressed = 0, released = 1.
- NES frame, 8 bits in order: A, B, Select, Start, Up, Down, Left, Right.
- SNES frame, 16 bits in order: B, Y, Select, Start, Up, Down, Left, Right, A, X, L, R, then four line-level 1 bits.
- After the last bit, the data line outputs fill level 0 until the next latch.

Edge detection:
- `ui_in[5]` and `ui_in[6]` are registered once more.
- Rising and falling edges are detected by comparing the current value with that registered copy.

States:
- IDLE
  - Data line = fill level 0 if EN, else 1.
  - Latch high -> LOAD.
- LOAD
  - Shift register reloads from BTN/XBTN/MODE every cycle while latch is high.
  - Data line = bit 0 of the frame.
  - Latch falling edge -> SHIFT; bit index = 0; POLLS += 1.
- SHIFT
  - Each clock rising edge: index += 1 and the shift register advances.
  - When index reaches 8 (NES) or 16 (SNES), data line = fill 0 and the state goes to DONE.
- DONE
  - Data line = fill 0.
  - Latch high -> LOAD.

Boundary rules:
- Latch rising edge in any state goes to LOAD, restarting the frame mid-sequence.
- Latch rising edge takes priority over a clock edge in the same cycle.
- Clock edges in IDLE, LOAD and DONE are ignored.
- BTN/XBTN/MODE writes during SHIFT or DONE affect only the next frame. A write during LOAD is captured.
- EN=0 forces IDLE, data line = 1, and POLLS stops counting.
- Clearing EN mid-frame aborts the frame.

## Timing
- Reset values:
  - CTRL = 0, BTN = 0, XBTN = 0, POLLS = 0.
  - State IDLE, index 0.
  - `uo_out` = 0x02, i.e. data line 1 (disabled).
  - `data_out` follows the reset register values.
- Pad-pin edge to `uo_out[1]` change: 4 `clk` cycles (2 sync, 1 edge register, 1 output register).
- The data line is registered and glitch-free.
- Minimum console clock half-period supported: 8 `clk` cycles, i.e. 125 ns. Real pads run at 6 µs.
- Register write to read-back: 1 cycle.

## Configuration
- `TQVP_SNES_EMU_TIMEOUT_EN` defined:
  - A 16-bit counter runs in SHIFT and restarts on each clock edge.
  - If 65535 cycles (~1.02 ms) pass with no clock edge, the state goes to IDLE and the data line goes to fill level.
  - CTRL bit 2 reads 1 (sticky TIMEOUT flag). A write to CTRL clears it.
- Undefined:
  - No counter; SHIFT waits indefinitely.
  - CTRL bit 2 reads 0.

## Test plan
- Reset -> `uo_out`=0x02, all reads 0.
- NES mode: CTRL=0x02, BTN=0x81. Latch pulse, then 8 clocks -> wire bits 0,1,1,1,1,1,1,0, then 0. POLLS=1.
- SNES mode: CTRL=0x03, BTN=0x40, XBTN=0x09. 16 clocks -> wire bits 0,1,1,1,1,1,1,1,1,0,1,0,1,1,1,1, then 0.
- NES mode, BTN=0x00:
  - Latch again after 3 clocks -> frame restarts, bit 0 = 1 again, POLLS=2.
  - Write BTN=0xFF during SHIFT -> current frame unchanged; next frame is all 0.
- Set EN=0 mid-frame -> data line 1 within 1 cycle. Subsequent latches leave POLLS unchanged.
- With `TQVP_SNES_EMU_TIMEOUT_EN`: latch, 2 clocks, stall 65535 cycles -> IDLE, CTRL reads 0x07. Write CTRL=0x03 -> reads 0x03.

Source files
------------

// File: rtl/tqvp_snes_controller_emulator_if.sv
// Register bus and PMOD pins of the SNES/NES pad emulator peripheral.
`timescale 1ns/1ps

interface tqvp_snes_controller_emulator_if;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (
        output ui_in,
        output address,
        output data_write,
        output data_in,
        input  uo_out,
        input  data_out
    );

    modport slave (
        input  ui_in,
        input  address,
        input  data_write,
        input  data_in,
        output uo_out,
        output data_out
    );
endinterface

// File: rtl/tqvp_snes_controller_emulator.sv
// Controller-side NES/SNES serial pad: shifts CPU-programmed buttons out on latch/clock.
// Optional shift-stall timeout enabled by defining TQVP_SNES_EMU_TIMEOUT_EN.
`timescale 1ns/1ps

module tqvp_snes_controller_emulator (
    input  logic clk,
    input  logic rst_n,
    tqvp_snes_controller_emulator_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Wire-level frame, bit 0 goes out first; pressed buttons drive 0.
    function automatic logic [15:0] build_frame(input logic snes, input logic [7:0] btn,
                                                input logic [3:0] xbtn);
        logic [15:0] f;
        if (snes) begin
            f = {4'hF, ~xbtn[0], ~xbtn[1], ~xbtn[3], ~btn[7],
                 ~btn[0], ~btn[1], ~btn[2], ~btn[3], ~btn[4], ~btn[5], ~xbtn[2], ~btn[6]};
        end else begin
            f = {8'h00, ~btn[0], ~btn[1], ~btn[2], ~btn[3], ~btn[4], ~btn[5], ~btn[6], ~btn[7]};
        end
        return f;
    endfunction

    logic        mode_r;
    logic        en_r;
    logic [7:0]  btn_r;
    logic [3:0]  xbtn_r;
    logic [7:0]  polls_r;
    logic        latch_d_r;
    logic        pclk_d_r;
    logic [1:0]  state_r;
    logic [4:0]  idx_r;
    logic [15:0] shift_r;
    logic        snes_r;
    logic        data_r;

    logic        latch_s;
    logic        latch_rise_s;
    logic        latch_fall_s;
    logic        pclk_rise_s;
    logic        wr_ctrl_s;
    logic        wr_btn_s;
    logic        wr_xbtn_s;
    logic        wr_polls_s;
    logic        en_nxt_s;
    logic [15:0] frame_s;
    logic [4:0]  idx_inc_s;
    logic        last_s;
    logic        timeout_hit_s;
    logic        timeout_flag_s;
    logic [1:0]  state_nxt_s;
    logic [4:0]  idx_nxt_s;
    logic [15:0] shift_nxt_s;
    logic        snes_nxt_s;
    logic        poll_inc_s;
    logic        data_nxt_s;
    logic        unused_ok_s;

    assign latch_s      = bus.ui_in[5];
    assign latch_rise_s = latch_s & ~latch_d_r;
    assign latch_fall_s = ~latch_s & latch_d_r;
    assign pclk_rise_s  = bus.ui_in[6] & ~pclk_d_r;
    assign unused_ok_s  = ^{bus.ui_in[7], bus.ui_in[4:0]};

    assign wr_ctrl_s  = bus.data_write && (bus.address == 4'h0);
    assign wr_btn_s   = bus.data_write && (bus.address == 4'h1);
    assign wr_xbtn_s  = bus.data_write && (bus.address == 4'h2);
    assign wr_polls_s = bus.data_write && (bus.address == 4'h3);
    assign en_nxt_s   = wr_ctrl_s ? bus.data_in[1] : en_r;

    assign frame_s   = build_frame(mode_r, btn_r, xbtn_r);
    assign idx_inc_s = idx_r + 5'd1;
    assign last_s    = snes_r ? (idx_inc_s == 5'd16) : (idx_inc_s == 5'd8);

`ifdef TQVP_SNES_EMU_TIMEOUT_EN
    logic [15:0] to_cnt_r;
    logic        timeout_r;

    assign timeout_hit_s  = en_r && (state_r == ST_SHIFT) && !latch_rise_s && !pclk_rise_s
                            && (to_cnt_r == 16'hFFFF);
    assign timeout_flag_s = timeout_r;

    // Stall counter since the last console clock edge, plus sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_r  <= 16'h0000;
            timeout_r <= 1'b0;
        end else begin
            if ((state_r != ST_SHIFT) || pclk_rise_s) begin
                to_cnt_r <= 16'h0000;
            end else if (to_cnt_r != 16'hFFFF) begin
                to_cnt_r <= to_cnt_r + 16'd1;
            end else begin
                to_cnt_r <= to_cnt_r;
            end
            if (wr_ctrl_s) begin
                timeout_r <= 1'b0;
            end else if (timeout_hit_s) begin
                timeout_r <= 1'b1;
            end else begin
                timeout_r <= timeout_r;
            end
        end
    end
`else
    assign timeout_hit_s  = 1'b0;
    assign timeout_flag_s = 1'b0;
`endif

    // Frame sequencing; a latch rise restarts the frame from any state.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        shift_nxt_s = shift_r;
        snes_nxt_s  = snes_r;
        poll_inc_s  = 1'b0;
        if (!en_r) begin
            state_nxt_s = ST_IDLE;
            idx_nxt_s   = 5'd0;
        end else if (latch_rise_s) begin
            state_nxt_s = ST_LOAD;
            idx_nxt_s   = 5'd0;
            shift_nxt_s = frame_s;
            snes_nxt_s  = mode_r;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (latch_s) begin
                        state_nxt_s = ST_LOAD;
                        idx_nxt_s   = 5'd0;
                        shift_nxt_s = frame_s;
                        snes_nxt_s  = mode_r;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_LOAD: begin
                    shift_nxt_s = frame_s;
                    snes_nxt_s  = mode_r;
                    if (latch_fall_s) begin
                        state_nxt_s = ST_SHIFT;
                        idx_nxt_s   = 5'd0;
                        poll_inc_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end
                ST_SHIFT: begin
                    if (timeout_hit_s) begin
                        state_nxt_s = ST_IDLE;
                        idx_nxt_s   = 5'd0;
                    end else if (pclk_rise_s) begin
                        idx_nxt_s   = idx_inc_s;
                        shift_nxt_s = {1'b0, shift_r[15:1]};
                        state_nxt_s = last_s ? ST_DONE : ST_SHIFT;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    idx_nxt_s   = 5'd0;
                end
            endcase
        end
    end

    // Next data-line level; disabling takes effect on the same edge as the CTRL write.
    always_comb begin
        data_nxt_s = 1'b0;
        if (!en_nxt_s) begin
            data_nxt_s = 1'b1;
        end else begin
            case (state_r)
                ST_LOAD, ST_SHIFT: data_nxt_s = shift_r[0];
                default:           data_nxt_s = 1'b0;
            endcase
        end
    end

    // CPU-visible registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r  <= 1'b0;
            en_r    <= 1'b0;
            btn_r   <= 8'h00;
            xbtn_r  <= 4'h0;
            polls_r <= 8'h00;
        end else begin
            if (wr_ctrl_s) begin
                mode_r <= bus.data_in[0];
                en_r   <= bus.data_in[1];
            end else begin
                mode_r <= mode_r;
                en_r   <= en_r;
            end
            btn_r  <= wr_btn_s  ? bus.data_in      : btn_r;
            xbtn_r <= wr_xbtn_s ? bus.data_in[3:0] : xbtn_r;
            if (wr_polls_s) begin
                polls_r <= 8'h00;
            end else if (poll_inc_s) begin
                polls_r <= polls_r + 8'd1;
            end else begin
                polls_r <= polls_r;
            end
        end
    end

    // Pin edge history, protocol state and the registered data line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch_d_r <= 1'b0;
            pclk_d_r  <= 1'b0;
            state_r   <= ST_IDLE;
            idx_r     <= 5'd0;
            shift_r   <= 16'h0000;
            snes_r    <= 1'b0;
            data_r    <= 1'b1;
        end else begin
            latch_d_r <= latch_s;
            pclk_d_r  <= bus.ui_in[6];
            state_r   <= state_nxt_s;
            idx_r     <= idx_nxt_s;
            shift_r   <= shift_nxt_s;
            snes_r    <= snes_nxt_s;
            data_r    <= data_nxt_s;
        end
    end

    // Register read mux.
    always_comb begin
        bus.data_out = 8'h00;
        case (bus.address)
            4'h0:    bus.data_out = {5'b00000, timeout_flag_s, en_r, mode_r};
            4'h1:    bus.data_out = btn_r;
            4'h2:    bus.data_out = {4'h0, xbtn_r};
            4'h3:    bus.data_out = polls_r;
            default: bus.data_out = 8'h00;
        endcase
    end

    assign bus.uo_out = {6'b000000, data_r, 1'b0};

endmodule

// File: tb/tb_tqvp_snes_controller_emulator.sv
// Directed bench for the NES/SNES pad emulator: frame table plus corner-case sequences.
`timescale 1ns/1ps

module tb_tqvp_snes_controller_emulator;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    tqvp_snes_controller_emulator_if bus();

    tqvp_snes_controller_emulator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ctrl;
        logic [7:0]  btn;
        logic [7:0]  xbtn;
        logic [15:0] wire_bits;
        int          nbits;
        logic [7:0]  polls;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.data_in    = d;
        bus.data_write = 1'b1;
        @(negedge clk);
        bus.data_write = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [3:0] a, input logic [7:0] exp);
        @(negedge clk);
        bus.address = a;
        #1;
        check(name, {8'h00, bus.data_out}, {8'h00, exp});
    endtask

    task automatic chk_line(input string name, input logic b);
        check(name, {8'h00, bus.uo_out}, {8'h00, 6'b000000, b, 1'b0});
    endtask

    task automatic set_latch(input logic v);
        bus.ui_in[5] = v;
        cycles(8);
    endtask

    task automatic set_pclk(input logic v);
        bus.ui_in[6] = v;
        cycles(8);
    endtask

    task automatic pulse_latch();
        set_latch(1'b1);
        set_latch(1'b0);
    endtask

    task automatic pulse_pclk();
        set_pclk(1'b1);
        set_pclk(1'b0);
    endtask

    task automatic run_frame(input logic [15:0] bits, input int nbits, input string tag);
        pulse_latch();
        chk_line({tag, " bit0"}, bits[0]);
        for (int i = 1; i <= nbits; i++) begin
            pulse_pclk();
            if (i < nbits) chk_line($sformatf("%s bit%0d", tag, i), bits[i]);
            else           chk_line({tag, " fill"}, 1'b0);
        end
        pulse_pclk();
        chk_line({tag, " done ignores clock"}, 1'b0);
    endtask

    initial begin
        vecs[0] = '{8'h02, 8'h81, 8'h00, 16'h007E, 8,  8'd1};
        vecs[1] = '{8'h03, 8'h40, 8'h09, 16'hF5FE, 16, 8'd2};
        vecs[2] = '{8'h02, 8'h00, 8'h00, 16'h00FF, 8,  8'd3};
        vecs[3] = '{8'h03, 8'hFF, 8'hFF, 16'hF000, 16, 8'd4};
        vecs[4] = '{8'hFE, 8'h5A, 8'h00, 16'h00A5, 8,  8'd5};
        vecs[5] = '{8'h03, 8'h81, 8'h06, 16'hFA7D, 16, 8'd6};

        bus.ui_in      = 8'h00;
        bus.address    = 4'h0;
        bus.data_write = 1'b0;
        bus.data_in    = 8'h00;
        rst_n          = 1'b0;
        cycles(3);
        chk_line("reset line", 1'b1);
        rst_n = 1'b1;
        cycles(2);
        chk_line("post-reset line", 1'b1);
        rd_check("reset CTRL", 4'h0, 8'h00);
        rd_check("reset BTN", 4'h1, 8'h00);
        rd_check("reset XBTN", 4'h2, 8'h00);
        rd_check("reset POLLS", 4'h3, 8'h00);
        rd_check("reset addr F", 4'hF, 8'h00);

        for (int v = 0; v < 6; v++) begin
            wr(4'h0, vecs[v].ctrl);
            wr(4'h1, vecs[v].btn);
            wr(4'h2, vecs[v].xbtn);
            rd_check($sformatf("vec%0d CTRL", v), 4'h0, vecs[v].ctrl & 8'h03);
            rd_check($sformatf("vec%0d BTN", v), 4'h1, vecs[v].btn);
            rd_check($sformatf("vec%0d XBTN", v), 4'h2, vecs[v].xbtn & 8'h0F);
            run_frame(vecs[v].wire_bits, vecs[v].nbits, $sformatf("vec%0d", v));
            rd_check($sformatf("vec%0d POLLS", v), 4'h3, vecs[v].polls);
        end

        // Latch mid-frame restarts from bit 0 and counts again.
        wr(4'h3, 8'h00);
        wr(4'h0, 8'h02);
        wr(4'h1, 8'h00);
        pulse_latch();
        for (int i = 0; i < 3; i++) pulse_pclk();
        chk_line("restart pre bit3", 1'b1);
        pulse_latch();
        chk_line("restart bit0", 1'b1);
        rd_check("restart POLLS", 4'h3, 8'd2);
        for (int i = 0; i < 7; i++) pulse_pclk();
        chk_line("restart bit7", 1'b1);
        pulse_pclk();
        chk_line("restart fill", 1'b0);

        // BTN write during SHIFT only affects the following frame.
        pulse_latch();
        pulse_pclk();
        pulse_pclk();
        wr(4'h1, 8'hFF);
        cycles(4);
        chk_line("midwrite bit2", 1'b1);
        for (int i = 3; i < 8; i++) begin
            pulse_pclk();
            chk_line($sformatf("midwrite bit%0d", i), 1'b1);
        end
        pulse_pclk();
        chk_line("midwrite fill", 1'b0);
        run_frame(16'h0000, 8, "nextframe");
        rd_check("midwrite POLLS", 4'h3, 8'd4);

        // Disabling mid-frame forces the line high at once and freezes POLLS.
        wr(4'h1, 8'h00);
        pulse_latch();
        pulse_pclk();
        pulse_pclk();
        wr(4'h0, 8'h00);
        chk_line("disable immediate", 1'b1);
        pulse_latch();
        pulse_pclk();
        chk_line("disabled line", 1'b1);
        rd_check("disabled POLLS", 4'h3, 8'd5);
        wr(4'h0, 8'h02);
        cycles(3);
        chk_line("reenable idle fill", 1'b0);
        set_latch(1'b1);
        chk_line("reenable load bit0", 1'b1);
        set_latch(1'b0);
        rd_check("reenable POLLS", 4'h3, 8'd6);

        // Latch rise and clock rise together: the latch wins.
        wr(4'h1, 8'h80);
        pulse_latch();
        pulse_pclk();
        pulse_pclk();
        chk_line("prio pre bit2", 1'b1);
        bus.ui_in[5] = 1'b1;
        bus.ui_in[6] = 1'b1;
        cycles(8);
        chk_line("prio load bit0", 1'b0);
        set_latch(1'b0);
        chk_line("prio shift bit0", 1'b0);
        set_pclk(1'b0);
        chk_line("prio clk fall", 1'b0);
        pulse_pclk();
        chk_line("prio bit1", 1'b1);
        rd_check("prio POLLS", 4'h3, 8'd8);

        // BTN write while latch is held is captured into the frame.
        wr(4'h1, 8'hFF);
        set_latch(1'b1);
        chk_line("load old bit0", 1'b0);
        wr(4'h1, 8'h7F);
        cycles(4);
        chk_line("load new bit0", 1'b1);
        set_latch(1'b0);
        chk_line("load shift bit0", 1'b1);

        // POLLS clear and unlisted addresses.
        wr(4'h3, 8'h55);
        rd_check("POLLS cleared", 4'h3, 8'h00);
        wr(4'h4, 8'hFF);
        rd_check("addr4 reads 0", 4'h4, 8'h00);
        rd_check("BTN kept", 4'h1, 8'h7F);
        rd_check("CTRL kept", 4'h0, 8'h02);

`ifdef TQVP_SNES_EMU_TIMEOUT_EN
        wr(4'h0, 8'h03);
        pulse_latch();
        pulse_pclk();
        pulse_pclk();
        repeat (65540) @(negedge clk);
        chk_line("timeout fill", 1'b0);
        rd_check("timeout CTRL", 4'h0, 8'h07);
        wr(4'h0, 8'h03);
        rd_check("timeout cleared", 4'h0, 8'h03);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
